// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: store-size encodings and store-unit FSM states.
package cpu_defs_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } store_state_t;

  // True when a store request cannot be serviced: reserved size or misaligned.
  function automatic logic store_req_bad(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_WORD: bad = (lane != 2'b00);
      SZ_HALF: bad = lane[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Little-endian lane merge: overlays the low byte/half of wdata onto rdata.
module lane_merge
  import cpu_defs_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  // Replace only the addressed lanes; everything else passes through from rdata.
  always_comb begin
    merged = rdata;
    case (size)
      SZ_WORD: merged = wdata;
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      SZ_BYTE: merged[{lane, 3'b000} +: 8] = wdata[7:0];
      default: merged = rdata;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit: word stores write directly; byte/half stores read the word,
// merge the new lanes in, and write it back.
module store_rmw_unit
  import cpu_defs_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              start,
  input  logic [1:0]        StoreSize,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Counter preload: zero means the read data arrives in the first WAIT cycle.
  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  store_state_t      state_reg;
  logic [1:0]        size_reg;
  logic [1:0]        lane_reg;
  logic [31:0]       wdata_reg;
  logic [1:0]        cnt_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              rd_en_reg;
  logic              wr_en_reg;
  logic [31:0]       mem_wdata_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;
  logic [31:0]       merged_next;

  // Merge straight from the memory bus so capture and merge happen in one edge.
  lane_merge u_lane_merge (
    .rdata  (mem_rdata),
    .wdata  (wdata_reg),
    .size   (size_reg),
    .lane   (lane_reg),
    .merged (merged_next)
  );

  // Store sequencer with registered memory strobes and status pulses.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg     <= ST_IDLE;
      size_reg      <= SZ_WORD;
      lane_reg      <= 2'b00;
      wdata_reg     <= '0;
      cnt_reg       <= '0;
      mem_addr_reg  <= '0;
      rd_en_reg     <= 1'b0;
      wr_en_reg     <= 1'b0;
      mem_wdata_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      rd_en_reg <= 1'b0;
      wr_en_reg <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          busy_reg <= 1'b0;
          if (start) begin
            size_reg  <= StoreSize;
            lane_reg  <= addr[1:0];
            wdata_reg <= wdata;
            if (store_req_bad(StoreSize, addr[1:0])) begin
              err_reg <= 1'b1;
            end else begin
              mem_addr_reg <= {addr[ADDR_W-1:2], 2'b00};
              busy_reg     <= 1'b1;
              if (StoreSize == SZ_WORD) begin
                mem_wdata_reg <= wdata;
                wr_en_reg     <= 1'b1;
                done_reg      <= 1'b1;
                state_reg     <= ST_WRITE;
              end else begin
                rd_en_reg <= 1'b1;
                state_reg <= ST_READ;
              end
            end
          end
        end
        ST_READ: begin
          cnt_reg   <= WAIT_INIT;
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_reg == 2'd0) begin
            mem_wdata_reg <= merged_next;
            wr_en_reg     <= 1'b1;
            done_reg      <= 1'b1;
            state_reg     <= ST_WRITE;
          end else begin
            cnt_reg <= cnt_reg - 2'd1;
          end
        end
        ST_WRITE: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr  = mem_addr_reg;
  assign mem_rd_en = rd_en_reg;
  assign mem_wr_en = wr_en_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: two instances (RD_LAT=1 and RD_LAT=3), each with
// a latency-accurate memory model, checked by a scoreboard of expected writes.
module tb_store_rmw_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st[2];
  logic [1:0]  sz[2];
  logic [31:0] ad[2];
  logic [31:0] wd[2];
  logic [31:0] ma[2];
  logic        re[2];
  logic [31:0] rdat[2];
  logic        we[2];
  logic [31:0] mwd[2];
  logic        bz[2];
  logic        dn[2];
  logic        er[2];
  logic [31:0] memw[2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rd_seen = 0;

  typedef struct {
    int          inst;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memw;
    bit          exp_err;
    logic [31:0] exp_wd;
    int          lat;
  } vec_t;

  typedef struct {
    int          inst;
    logic [31:0] addr;
    bit          err;
    bit          sub;
    logic [31:0] wd;
    int          start;
    int          lat;
  } exp_t;

  vec_t vecs[13];
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  store_rmw_unit #(.ADDR_W(32), .RD_LAT(1)) u0 (
    .CLK(clk), .Reset(rst), .start(st[0]), .StoreSize(sz[0]), .addr(ad[0]),
    .wdata(wd[0]), .mem_addr(ma[0]), .mem_rd_en(re[0]), .mem_rdata(rdat[0]),
    .mem_wr_en(we[0]), .mem_wdata(mwd[0]), .busy(bz[0]), .done(dn[0]), .err(er[0])
  );

  store_rmw_unit #(.ADDR_W(32), .RD_LAT(3)) u1 (
    .CLK(clk), .Reset(rst), .start(st[1]), .StoreSize(sz[1]), .addr(ad[1]),
    .wdata(wd[1]), .mem_addr(ma[1]), .mem_rd_en(re[1]), .mem_rdata(rdat[1]),
    .mem_wr_en(we[1]), .mem_wdata(mwd[1]), .busy(bz[1]), .done(dn[1]), .err(er[1])
  );

  // Memory models: data is only valid exactly RD_LAT cycles after the read strobe.
  logic        v0 = 1'b0;
  logic [31:0] p0 = '0;
  logic [2:0]  v1 = '0;
  logic [31:0] p1[3];
  always @(posedge clk) begin
    v0    <= re[0];
    p0    <= memw[0];
    v1    <= {v1[1:0], re[1]};
    p1[0] <= memw[1];
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign rdat[0] = v0    ? p0    : 32'hBAD0BAD0;
  assign rdat[1] = v1[2] ? p1[2] : 32'hBAD0BAD0;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d: got %h want %h (t=%0t)", name, inst, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares every write/err event against the queue head.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (re[i] && we[i]) chk("rd_wr_overlap", i, 32'(re[i] & we[i]), 32'd0);
      if (dn[i] && !we[i]) chk("done_without_wr", i, 32'(dn[i]), 32'(we[i]));
      if (q.size() > 0 && q[0].inst == i) begin
        if (re[i]) begin
          rd_seen = rd_seen + 1;
          chk("rd_addr", i, ma[i], q[0].addr);
          chk("busy_at_rd", i, 32'(bz[i]), 32'd1);
        end
        if (we[i] || er[i]) begin
          exp_t e;
          e = q.pop_front();
          chk("err_flag", i, 32'(er[i]), 32'(e.err));
          chk("latency", i, 32'(cyc - e.start), 32'(e.lat));
          if (e.err) begin
            chk("wr_on_err", i, 32'(we[i]), 32'd0);
            chk("busy_on_err", i, 32'(bz[i]), 32'd0);
            chk("rd_on_err", i, 32'(rd_seen), 32'd0);
          end else begin
            chk("done", i, 32'(dn[i]), 32'd1);
            chk("wr_addr", i, ma[i], e.addr);
            chk("wr_data", i, mwd[i], e.wd);
            chk("busy_at_wr", i, 32'(bz[i]), 32'd1);
            chk("rd_count", i, 32'(rd_seen), e.sub ? 32'd1 : 32'd0);
          end
          $display("txn inst%0d addr=%h err=%0d wdata=%h lat=%0d", i, e.addr, er[i], mwd[i], cyc - e.start);
        end
      end else if (we[i] || er[i]) begin
        chk("unexpected_event", i, {30'd0, we[i], er[i]}, 32'd0);
      end
    end
  end

  task automatic push_exp(input int i, input logic [1:0] s, input logic [31:0] a,
                          input bit e, input logic [31:0] ew, input int lat);
    exp_t x;
    x.inst  = i;
    x.addr  = {a[31:2], 2'b00};
    x.err   = e;
    x.sub   = (s == 2'b01) || (s == 2'b10);
    x.wd    = ew;
    x.start = cyc;
    x.lat   = lat;
    rd_seen = 0;
    q.push_back(x);
  endtask

  task automatic drive(input int i, input logic [1:0] s, input logic [31:0] a, input logic [31:0] w);
    sz[i] = s;
    ad[i] = a;
    wd[i] = w;
    st[i] = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() > 0) begin
      chk("timeout", q[0].inst, 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic run_txn(input vec_t v);
    @(negedge clk);
    memw[v.inst] = v.memw;
    push_exp(v.inst, v.sz, v.addr, v.exp_err, v.exp_wd, v.lat);
    drive(v.inst, v.sz, v.addr, v.wdata);
    @(negedge clk);
    st[v.inst] = 1'b0;
    #1;
    drain();
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; sz[i] = 2'b00; ad[i] = '0; wd[i] = '0; memw[i] = '0;
    end
    p1[0] = '0; p1[1] = '0; p1[2] = '0;

    vecs[0]  = '{0, 2'b00, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 32'hDEADBEEF, 1};
    vecs[1]  = '{0, 2'b10, 32'h102, 32'h000000AB, 32'h11223344, 1'b0, 32'h11AB3344, 3};
    vecs[2]  = '{0, 2'b01, 32'h206, 32'h0000CAFE, 32'h55667788, 1'b0, 32'hCAFE7788, 3};
    vecs[3]  = '{1, 2'b01, 32'h206, 32'h0000CAFE, 32'h55667788, 1'b0, 32'hCAFE7788, 5};
    vecs[4]  = '{0, 2'b01, 32'h101, 32'h0000FFFF, 32'h0,        1'b1, 32'h0,        1};
    vecs[5]  = '{0, 2'b00, 32'h102, 32'h12345678, 32'h0,        1'b1, 32'h0,        1};
    vecs[6]  = '{0, 2'b11, 32'h100, 32'h12345678, 32'h0,        1'b1, 32'h0,        1};
    vecs[7]  = '{0, 2'b10, 32'h103, 32'hFFFFFF5A, 32'h00000000, 1'b0, 32'h5A000000, 3};
    vecs[8]  = '{1, 2'b10, 32'h100, 32'h12345677, 32'hFFFFFFFF, 1'b0, 32'hFFFFFF77, 5};
    vecs[9]  = '{0, 2'b10, 32'h101, 32'h000000C3, 32'hA5A5A5A5, 1'b0, 32'hA5A5C3A5, 3};
    vecs[10] = '{0, 2'b01, 32'h300, 32'hFFFF1234, 32'hAAAABBBB, 1'b0, 32'hAAAA1234, 3};
    vecs[11] = '{1, 2'b00, 32'h7FC, 32'h0BADF00D, 32'h0,        1'b0, 32'h0BADF00D, 1};
    vecs[12] = '{1, 2'b01, 32'h102, 32'h0000BEEF, 32'h01234567, 1'b0, 32'hBEEF4567, 5};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_mem_addr", i, ma[i], 32'd0);
      chk("rst_rd_en", i, 32'(re[i]), 32'd0);
      chk("rst_wr_en", i, 32'(we[i]), 32'd0);
      chk("rst_wdata", i, mwd[i], 32'd0);
      chk("rst_busy", i, 32'(bz[i]), 32'd0);
      chk("rst_done", i, 32'(dn[i]), 32'd0);
      chk("rst_err", i, 32'(er[i]), 32'd0);
    end

    // Table-driven transactions (consecutive entries also exercise back-to-back starts)
    for (int k = 0; k < 13; k++) run_txn(vecs[k]);

    // Reset while in WAIT: the aborted store must never write
    @(negedge clk);
    memw[1] = 32'h99887766;
    drive(1, 2'b10, 32'h40, 32'h00000077);
    @(negedge clk);
    st[1] = 1'b0;
    @(negedge clk);
    chk("in_wait_busy", 1, 32'(bz[1]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mem_addr", 1, ma[1], 32'd0);
    chk("midrst_rd_en", 1, 32'(re[1]), 32'd0);
    chk("midrst_wr_en", 1, 32'(we[1]), 32'd0);
    chk("midrst_wdata", 1, mwd[1], 32'd0);
    chk("midrst_busy", 1, 32'(bz[1]), 32'd0);
    chk("midrst_done", 1, 32'(dn[1]), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    v = '{1, 2'b00, 32'h80, 32'h13579BDF, 32'h0, 1'b0, 32'h13579BDF, 1};
    run_txn(v);

    // Start while busy: second request during WAIT is ignored
    @(negedge clk);
    memw[1] = 32'hAABBCCDD;
    push_exp(1, 2'b10, 32'h101, 1'b0, 32'hAABB11DD, 5);
    drive(1, 2'b10, 32'h101, 32'h00000011);
    @(negedge clk);
    st[1] = 1'b0;
    @(negedge clk);
    drive(1, 2'b10, 32'h502, 32'h000000EE);
    @(negedge clk);
    st[1] = 1'b0;
    #1;
    drain();
    repeat (6) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
